// File: rtl/uart_pkg.sv
// Shared constants, types and helpers for the UART time-line transmitter.
// No logic of its own.
// ASCII codes, character-slot enumeration, snapshot struct, baud divisor.
package uart_pkg;

   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   typedef enum logic [3:0] {
      CH_HOUR_T  = 4'd0,
      CH_HOUR_U  = 4'd1,
      CH_COLON0  = 4'd2,
      CH_MIN_T   = 4'd3,
      CH_MIN_U   = 4'd4,
      CH_COLON1  = 4'd5,
      CH_SEC_T   = 4'd6,
      CH_SEC_U   = 4'd7,
      CH_CR      = 4'd8,
      CH_LF      = 4'd9
   } char_idx_t;

   // Only the BCD bits that matter are kept; mode/CH flags are dropped at latch time.
   typedef struct packed {
      logic [5:0] hour;
      logic [7:0] min;
      logic [6:0] sec;
   } time_snap_t;

   function automatic int calc_baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] n);
      return (n <= 4'd9) ? (ASCII_ZERO + {4'd0, n}) : ASCII_QMARK;
   endfunction

endpackage

// File: rtl/uart_time_tx_if.sv
// Request/status bundle between the time source and the time-line transmitter.
// Pure wiring, no latency.
// start is only honoured while busy is low.
interface uart_time_tx_if;
   logic       start;
   logic [7:0] bcd_hour;
   logic [7:0] bcd_min;
   logic [7:0] bcd_sec;
   logic       uart_tx;
   logic       busy;
   logic       done;

   modport master (output start, bcd_hour, bcd_min, bcd_sec,
                   input  uart_tx, busy, done);
   modport slave  (input  start, bcd_hour, bcd_min, bcd_sec,
                   output uart_tx, busy, done);
endinterface

// File: rtl/uart_byte_ser.sv
// 8N1 byte serialiser: start bit, D0..D7 LSB first, stop bit, BAUD_DIV cycles each.
// Start bit appears on the edge that accepts load_vld.
// load_rdy is high when idle or in the last stop-bit cycle, allowing gapless chaining.
module uart_byte_ser #(
   parameter int BAUD_DIV = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_vld,
   input  logic [7:0] load_dat,
   output logic       load_rdy,
   output logic       tx,
   output logic       pre_last,
   output logic       last
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(BAUD_DIV - 2);

   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          active;
   logic          bit_end;

   assign bit_end  = (baud_cnt == CNT_LAST);
   assign last     = active && (bit_cnt == 4'd9) && bit_end;
   assign pre_last = active && (bit_cnt == 4'd9) && (baud_cnt == CNT_PRE);
   assign load_rdy = !active || last;

   // bit_cnt: 0 start, 1..8 data, 9 stop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx       <= 1'b1;
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else if (load_vld && load_rdy) begin
         tx       <= 1'b0;
         active   <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= load_dat;
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               active  <= 1'b0;
               bit_cnt <= '0;
               tx      <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd8) begin
                  tx <= 1'b1;
               end else begin
                  tx    <= shreg[0];
                  shreg <= {1'b0, shreg[7:1]};
               end
            end
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_time_tx.sv
// Formats a latched BCD time snapshot as "HH:MM:SS\r\n" and sends it 8N1.
// Start bit one cycle after start is accepted; whole line is 100*BAUD_DIV cycles.
// No backpressure: start is ignored while busy; done pulses on the last stop-bit cycle.
module uart_time_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600,
   parameter int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD)
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_time_tx_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

   state_t     state;
   char_idx_t  idx;
   char_idx_t  sel_idx;
   time_snap_t snap;
   logic [7:0] sel_char;
   logic       busy_q;
   logic       done_q;
   logic       ser_vld;
   logic       ser_rdy;
   logic       ser_pre_last;
   logic       ser_last;
   logic       ser_tx;
   logic       unused_bits;

   assign unused_bits = ^{bus.bcd_hour[7:6], bus.bcd_sec[7]};

   // The next char is selected during the final stop-bit cycle so it chains without a gap.
   always_comb begin
      sel_idx  = (state == ST_LOAD) ? CH_HOUR_T : char_idx_t'(idx + 4'd1);
      sel_char = ASCII_LF;
      case (sel_idx)
         CH_HOUR_T: sel_char = bcd_to_ascii({2'b00, snap.hour[5:4]});
         CH_HOUR_U: sel_char = bcd_to_ascii(snap.hour[3:0]);
         CH_COLON0: sel_char = ASCII_COLON;
         CH_MIN_T:  sel_char = bcd_to_ascii(snap.min[7:4]);
         CH_MIN_U:  sel_char = bcd_to_ascii(snap.min[3:0]);
         CH_COLON1: sel_char = ASCII_COLON;
         CH_SEC_T:  sel_char = bcd_to_ascii({1'b0, snap.sec[6:4]});
         CH_SEC_U:  sel_char = bcd_to_ascii(snap.sec[3:0]);
         CH_CR:     sel_char = ASCII_CR;
         default:   sel_char = ASCII_LF;
      endcase
   end

   assign ser_vld = ser_rdy && ((state == ST_LOAD) ||
                    ((state == ST_SHIFT) && ser_last && (idx != CH_LF)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         idx    <= CH_HOUR_T;
         snap   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == ST_SHIFT) && (idx == CH_LF) && ser_pre_last;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  snap  <= '{hour: bus.bcd_hour[5:0], min: bus.bcd_min, sec: bus.bcd_sec[6:0]};
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state  <= ST_SHIFT;
               busy_q <= 1'b1;
               idx    <= CH_HOUR_T;
            end
            ST_SHIFT: begin
               if (ser_last) begin
                  if (idx == CH_LF) begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                     idx    <= CH_HOUR_T;
                  end else begin
                     idx <= char_idx_t'(idx + 4'd1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_byte_ser #(.BAUD_DIV(BAUD_DIV)) u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_vld (ser_vld),
      .load_dat (sel_char),
      .load_rdy (ser_rdy),
      .tx       (ser_tx),
      .pre_last (ser_pre_last),
      .last     (ser_last)
   );

   assign bus.uart_tx = ser_tx;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_uart_time_tx.sv
// Directed bench for uart_time_tx with BAUD_DIV=10; a mid-bit UART monitor
// pops expected characters from a scoreboard queue filled when each start is issued.
module tb_uart_time_tx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_time_tx_if u_if ();

   uart_time_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   int checks   = 0;
   int errors   = 0;
   int gen      = 0;
   int done_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_line(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      u_if.bcd_hour = h;
      u_if.bcd_min  = m;
      u_if.bcd_sec  = s;
   endtask

   task automatic pulse_start;
      @(negedge clk) u_if.start = 1'b1;
      @(negedge clk) u_if.start = 1'b0;
   endtask

   // Line cycles are numbered 0..999 starting at the first start-bit cycle.
   task automatic watch_line(input string tag, input int poke_at, input bit b2b, input string next_line);
      int done_at  = -1;
      int ndone    = 0;
      bit busy_bad = 1'b0;
      int last_c   = b2b ? 1001 : 1000;
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check({tag, " start bit"}, 32'(u_if.uart_tx), 32'd0);
            check({tag, " busy at start"}, 32'(u_if.busy), 32'd1);
         end
         if (u_if.done === 1'b1) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
         if (c < 1000 && u_if.busy !== 1'b1) busy_bad = 1'b1;
         if (c == poke_at) begin
            set_time(8'h01, 8'h02, 8'h03);
            u_if.start = 1'b1;
         end
         if (c == poke_at + 1) u_if.start = 1'b0;
         if (b2b && c == 999) u_if.start = 1'b1;
         if (b2b && c == 1000) push_line(next_line);
         if (b2b && c == 1001) u_if.start = 1'b0;
         if (c == 1000) check({tag, " busy after done"}, 32'(u_if.busy), 32'd0);
      end
      check({tag, " done cycle"}, 32'(done_at), 32'd999);
      check({tag, " done count"}, 32'(ndone), 32'd1);
      check({tag, " busy held"}, 32'(busy_bad), 32'd0);
   endtask

   task automatic idle_check(input string tag, input int n);
      bit went_low = 1'b0;
      int dc = done_cnt;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (u_if.uart_tx !== 1'b1) went_low = 1'b1;
      end
      check({tag, " line idle"}, 32'(went_low), 32'd0);
      check({tag, " no done"}, 32'(done_cnt - dc), 32'd0);
   endtask

   always @(negedge clk) if (u_if.done === 1'b1) done_cnt++;

   // Mid-bit monitor; bytes begun before a reset are discarded via gen.
   initial begin
      forever begin
         int g;
         logic [7:0] b;
         @(negedge u_if.uart_tx);
         g = gen;
         repeat (5) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = u_if.uart_tx;
         end
         if (g == gen && rst_n === 1'b1)
            check("rx byte", 32'(b), exp_q.size() > 0 ? 32'(exp_q.pop_front()) : 32'h100);
      end
   end

   initial begin
      int dc;
      u_if.start = 1'b0;
      set_time(8'h00, 8'h00, 8'h00);

      repeat (3) @(negedge clk);
      check("reset uart_tx", 32'(u_if.uart_tx), 32'd1);
      check("reset busy", 32'(u_if.busy), 32'd0);
      check("reset done", 32'(u_if.done), 32'd0);
      rst_n = 1'b1;
      idle_check("post-reset", 200);

      set_time(8'h23, 8'h59, 8'h07);
      push_line("23:59:07\r\n");
      pulse_start();
      watch_line("normal", -1, 1'b0, "");
      repeat (5) @(negedge clk);

      set_time(8'hC9, 8'h5A, 8'h80);
      push_line("09:5?:00\r\n");
      pulse_start();
      watch_line("mask", -1, 1'b0, "");
      repeat (5) @(negedge clk);

      set_time(8'h12, 8'h34, 8'h56);
      push_line("12:34:56\r\n");
      pulse_start();
      watch_line("snapshot", 300, 1'b0, "");
      idle_check("snapshot", 150);

      set_time(8'h17, 8'h45, 8'h30);
      push_line("17:45:30\r\n");
      pulse_start();
      repeat (451) @(negedge clk);
      dc = done_cnt;
      #1 rst_n = 1'b0;
      #1;
      check("abort uart_tx", 32'(u_if.uart_tx), 32'd1);
      check("abort busy", 32'(u_if.busy), 32'd0);
      check("abort done", 32'(u_if.done), 32'd0);
      gen++;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (150) @(negedge clk);
      check("abort no done", 32'(done_cnt - dc), 32'd0);
      check("abort line idle", 32'(u_if.uart_tx), 32'd1);
      set_time(8'h08, 8'h15, 8'h42);
      push_line("08:15:42\r\n");
      pulse_start();
      watch_line("post-abort", -1, 1'b0, "");
      repeat (5) @(negedge clk);

      set_time(8'h00, 8'h00, 8'h00);
      push_line("00:00:00\r\n");
      pulse_start();
      set_time(8'h19, 8'h08, 8'h47);
      watch_line("b2b first", -1, 1'b1, "19:08:47\r\n");
      watch_line("b2b second", -1, 1'b0, "");

      repeat (20) @(negedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
